mem_controller: RTL and testbench
=================================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles to wait for a host response before aborting, range 1-65535.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 instrMiss  in  1  iCache miss level, held until mcInstrValid.
REQ-005 instrAddr  in  32  word address of the missing instruction.
REQ-006 dataMiss  in  1  dCache miss level, held until mcDataValid.
REQ-007 dataAddr  in  32  word address of the missing data (CPU aluResult).
REQ-008 dataEvict  in  1  dCache evict level (CPU dCacheEvict), held until evictDone.
REQ-009 evictAddr  in  32  word address of the victim line.
REQ-010 evictData  in  512  victim line (CPU dCacheOut).
REQ-011 mcInstrValid  out  1  one-cycle pulse; mcInstrIn is valid.
REQ-012 mcInstrIn  out  512  instruction line returned to the fetch stage.
REQ-013 mcDataValid  out  1  one-cycle pulse; mcDataIn is valid.
REQ-014 mcDataIn  out  512  data line returned to the memory stage.
REQ-015 evictDone  out  1  one-cycle pulse; the victim line is committed to host memory.
REQ-016 hostReq  out  1  host request valid.
REQ-017 hostWrite  out  1  1 = write request, 0 = read request; qualified by hostReq.
REQ-018 hostAddr  out  32  line-aligned word address {addr[31:4],4'b0}.
REQ-019 hostWrData  out  512  write line; qualified by hostReq&hostWrite.
REQ-020 hostReqReady  in  1  host accepts the request in the cycle where hostReq&hostReqReady.
REQ-021 hostRdValid  in  1  read response valid.
REQ-022 hostRdData  in  512  read response line.
REQ-023 hostWrAck  in  1  write completion.
REQ-024 memTimeoutErr  out  1  one-cycle pulse when a host transaction times out.

Function
REQ-025 FSM states SHALL be: IDLE, REQ, WAIT, RESP.
REQ-026 In IDLE, priority SHALL be dataEvict > dataMiss > instrMiss; the winner's address and data, and whether it is a write, SHALL be latched and the FSM SHALL enter REQ on the next cycle.
REQ-027 A simultaneous dataEvict and dataMiss SHALL service the evict first, so write-back precedes refill.
REQ-028 In REQ, hostReq SHALL be 1 with latched hostWrite, hostAddr and hostWrData held stable; on hostReq&hostReqReady the FSM SHALL go to WAIT.
REQ-029 In WAIT, a read SHALL complete on hostRdValid and a write SHALL complete on hostWrAck; hostRdData SHALL be captured on that cycle, and the FSM SHALL go to RESP.
REQ-030 In RESP, exactly one of mcInstrValid, mcDataValid or evictDone SHALL pulse for one cycle, according to the latched source, with mcInstrIn or mcDataIn equal to the captured line; the FSM SHALL then return to IDLE.
REQ-031 The source just serviced SHALL be ignored in the IDLE cycle immediately following RESP, giving the cache one cycle to deassert its level.
REQ-032 hostRdValid or hostWrAck in IDLE or REQ SHALL be ignored.
REQ-033 Timeout counter behaviour SHALL be:
- 16-bit, cleared on entering REQ, increments in REQ and WAIT.
- On reaching TIMEOUT: memTimeoutErr pulses, no completion pulse is issued, and the FSM returns to IDLE.
- The request is re-arbitrated if the requester still holds it.
REQ-034 Minimum latency SHALL be 4 cycles from request assertion to the completion pulse when hostReqReady and the response arrive immediately (IDLE→REQ→WAIT→RESP).
REQ-035 mcInstrIn and mcDataIn SHALL hold their last captured value between pulses.
REQ-036 Only one host transaction SHALL be outstanding at any time.

Reset
REQ-037 On rst, all of the following SHALL hold on the next cycle, including mid-transaction:
- FSM = IDLE, counter = 0.
- hostReq, hostWrite, mcInstrValid, mcDataValid, evictDone and memTimeoutErr = 0.
- hostAddr, hostWrData, mcInstrIn and mcDataIn = 0.
REQ-038 No completion pulse SHALL be generated for a transaction aborted by rst; a late host response after rst SHALL be ignored per REQ-032.

Verification
REQ-039 instrMiss=1, instrAddr=0x0000_1237, hostReqReady=1, hostRdValid one cycle after accept with data 0xA5..A5 -> hostAddr=0x0000_1230, hostWrite=0, mcInstrValid pulses at cycle 4 with mcInstrIn=0xA5..A5.
REQ-040 dataEvict, dataMiss and instrMiss all asserted in the same cycle -> order is write (evictAddr) then data read then instruction read, with evictDone, mcDataValid and mcInstrValid each pulsing once.
REQ-041 hostReqReady held 0 for 10 cycles -> hostReq, hostAddr and hostWrData stay stable all 10 cycles, and the transaction proceeds on the first ready cycle.
REQ-042 TIMEOUT=8, host never responds -> memTimeoutErr pulses 8 cycles after entering REQ, no mcDataValid, FSM back in IDLE.
REQ-043 rst asserted in WAIT, then hostRdValid one cycle later -> all outputs 0, no mcDataValid pulse.
REQ-044 dataMiss held one extra cycle after mcDataValid -> no second read issued in that cycle.

Source files
------------

// File: rtl/mem_controller_if.sv
// Host-side memory bus: the controller drives requests (master), host memory answers (slave).
interface mem_controller_if;
    logic         hostReq;
    logic         hostWrite;
    logic [31:0]  hostAddr;
    logic [511:0] hostWrData;
    logic         hostReqReady;
    logic         hostRdValid;
    logic [511:0] hostRdData;
    logic         hostWrAck;

    modport master (
        output hostReq, hostWrite, hostAddr, hostWrData,
        input  hostReqReady, hostRdValid, hostRdData, hostWrAck
    );

    modport slave (
        input  hostReq, hostWrite, hostAddr, hostWrData,
        output hostReqReady, hostRdValid, hostRdData, hostWrAck
    );
endinterface

// File: rtl/mem_controller.sv
// Single-outstanding line-fill / write-back controller between the i/d caches and host memory.
// Evict beats data miss beats instruction miss; a stuck host is abandoned after TIMEOUT cycles.
module mem_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instrMiss,
    input  logic [31:0]  instrAddr,
    input  logic         dataMiss,
    input  logic [31:0]  dataAddr,
    input  logic         dataEvict,
    input  logic [31:0]  evictAddr,
    input  logic [511:0] evictData,
    output logic         mcInstrValid,
    output logic [511:0] mcInstrIn,
    output logic         mcDataValid,
    output logic [511:0] mcDataIn,
    output logic         evictDone,
    output logic         memTimeoutErr,
    mem_controller_if.master host
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} stateT;
    typedef enum logic [1:0] {SRC_INSTR, SRC_DATA, SRC_EVICT} srcT;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    stateT       state, stateNext;
    srcT         src, grantSrc;
    logic        grant, timeoutHit, done, timeoutPulse;
    logic [31:0] grantAddr;
    logic [15:0] cnt;
    logic [2:0]  srcMask, ignoreSrc;

    assign srcMask = {src == SRC_EVICT, src == SRC_DATA, src == SRC_INSTR};
    assign done    = (src == SRC_EVICT) ? host.hostWrAck : host.hostRdValid;

    always_comb begin
        stateNext  = state;
        grant      = 1'b0;
        grantSrc   = SRC_INSTR;
        grantAddr  = instrAddr;
        timeoutHit = 1'b0;
        case (state)
            IDLE: begin
                // ignoreSrc masks the requester just serviced while its level falls
                if (dataEvict && !ignoreSrc[2]) begin
                    grant     = 1'b1;
                    grantSrc  = SRC_EVICT;
                    grantAddr = evictAddr;
                end else if (dataMiss && !ignoreSrc[1]) begin
                    grant     = 1'b1;
                    grantSrc  = SRC_DATA;
                    grantAddr = dataAddr;
                end else if (instrMiss && !ignoreSrc[0]) begin
                    grant     = 1'b1;
                end
                if (grant) stateNext = REQ;
            end
            REQ: begin
                if (host.hostReqReady) begin
                    stateNext = WAIT;
                end else if (cnt >= LAST_CNT) begin
                    stateNext  = IDLE;
                    timeoutHit = 1'b1;
                end
            end
            WAIT: begin
                if (done) begin
                    stateNext = RESP;
                end else if (cnt >= LAST_CNT) begin
                    stateNext  = IDLE;
                    timeoutHit = 1'b1;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign host.hostReq  = (state == REQ);
    assign mcInstrValid  = (state == RESP) && (src == SRC_INSTR);
    assign mcDataValid   = (state == RESP) && (src == SRC_DATA);
    assign evictDone     = (state == RESP) && (src == SRC_EVICT);
    assign memTimeoutErr = timeoutPulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            src             <= SRC_INSTR;
            cnt             <= '0;
            ignoreSrc       <= '0;
            timeoutPulse    <= 1'b0;
            host.hostWrite  <= 1'b0;
            host.hostAddr   <= '0;
            host.hostWrData <= '0;
            mcInstrIn       <= '0;
            mcDataIn        <= '0;
        end else begin
            state        <= stateNext;
            timeoutPulse <= timeoutHit;
            // zero while idle, so every transaction starts counting from 0 in REQ
            cnt          <= (state == REQ || state == WAIT) ? cnt + 16'd1 : '0;
            ignoreSrc    <= (state == RESP) ? srcMask : '0;
            if (grant) begin
                src             <= grantSrc;
                host.hostWrite  <= (grantSrc == SRC_EVICT);
                host.hostAddr   <= grantAddr & 32'hFFFF_FFF0;
                host.hostWrData <= (grantSrc == SRC_EVICT) ? evictData : '0;
            end
            if (state == WAIT && done && src != SRC_EVICT) begin
                if (src == SRC_INSTR) mcInstrIn <= host.hostRdData;
                else                  mcDataIn  <= host.hostRdData;
            end
        end
    end
endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: vector table plus scoreboard, reactive host model, and a
// second instance with a short TIMEOUT for the abort path.
module tb_mem_controller;
    logic clk, rst;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    logic         instrMiss, dataMiss, dataEvict;
    logic [31:0]  instrAddr, dataAddr, evictAddr;
    logic [511:0] evictData;
    logic         mcInstrValid, mcDataValid, evictDone, memTimeoutErr;
    logic [511:0] mcInstrIn, mcDataIn;

    logic         dm2;
    logic         instrValid2, dataValid2, evictDone2, err2;
    logic [511:0] instrIn2, dataIn2;

    mem_controller_if ifc ();
    mem_controller_if ifc2 ();

    mem_controller dut (
        .clk(clk), .rst(rst),
        .instrMiss(instrMiss), .instrAddr(instrAddr),
        .dataMiss(dataMiss), .dataAddr(dataAddr),
        .dataEvict(dataEvict), .evictAddr(evictAddr), .evictData(evictData),
        .mcInstrValid(mcInstrValid), .mcInstrIn(mcInstrIn),
        .mcDataValid(mcDataValid), .mcDataIn(mcDataIn),
        .evictDone(evictDone), .memTimeoutErr(memTimeoutErr),
        .host(ifc)
    );

    mem_controller #(.TIMEOUT(8)) dut2 (
        .clk(clk), .rst(rst),
        .instrMiss(1'b0), .instrAddr(32'h0),
        .dataMiss(dm2), .dataAddr(32'h0000_4447),
        .dataEvict(1'b0), .evictAddr(32'h0), .evictData(512'h0),
        .mcInstrValid(instrValid2), .mcInstrIn(instrIn2),
        .mcDataValid(dataValid2), .mcDataIn(dataIn2),
        .evictDone(evictDone2), .memTimeoutErr(err2),
        .host(ifc2)
    );

    typedef struct {
        int           kind;      // 0 instr, 1 data, 2 evict
        logic [31:0]  addr;
        logic [511:0] line;
        int           readyDly;
        int           respDly;
        logic [31:0]  expAddr;
    } vecT;

    typedef struct {
        int           kind;
        logic [31:0]  addr;
        logic [511:0] line;
        int           expCyc;    // -1 = latency not checked
    } sbT;

    sbT           sb[$];
    vecT          vecs[7];
    logic [511:0] memLine[16];
    int           readyDelay = 0, respDelay = 0;

    int passCnt = 0, totalCnt = 0;
    int iCnt = 0, dCnt = 0, eCnt = 0, reqRises = 0;
    int dropI = 0, dropD = 0, dropE = 0;
    bit holdExtra = 1'b0;
    bit prevReq = 1'b0, prevReq2 = 1'b0;
    logic [31:0]  prevAddr;
    logic [511:0] prevWrData;
    int err2Cnt = 0, err2Cyc = 0, req2Cyc = 0, dv2Cnt = 0;

    // host memory model: reads come from memLine, ready after readyDelay stalled cycles
    initial begin
        int stall, respCnt;
        bit pending, pendW, acc;
        logic [31:0] pendA;
        stall = 0; respCnt = 0; pending = 0; pendW = 0; pendA = '0;
        ifc.hostReqReady = 1'b0;
        ifc.hostRdValid  = 1'b0;
        ifc.hostWrAck    = 1'b0;
        ifc.hostRdData   = '0;
        forever begin
            @(negedge clk);
            acc = ifc.hostReq && ifc.hostReqReady;
            if (acc) begin
                pending = 1'b1;
                pendW   = ifc.hostWrite;
                pendA   = ifc.hostAddr;
                respCnt = respDelay;
                stall   = 0;
            end else if (ifc.hostReq) begin
                stall++;
            end
            @(posedge clk);
            #1;
            ifc.hostRdValid = 1'b0;
            ifc.hostWrAck   = 1'b0;
            ifc.hostRdData  = '0;
            if (pending) begin
                if (respCnt == 0) begin
                    pending = 1'b0;
                    if (pendW) ifc.hostWrAck = 1'b1;
                    else begin
                        ifc.hostRdValid = 1'b1;
                        ifc.hostRdData  = memLine[pendA[7:4]];
                    end
                end else begin
                    respCnt--;
                end
            end
            ifc.hostReqReady = ifc.hostReq && (stall >= readyDelay);
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // one clock: sample/score at negedge, then apply cache level drops at posedge+1
    task automatic tick();
        sbT e;
        logic [2:0] p;
        @(negedge clk);
        p = {evictDone, mcDataValid, mcInstrValid};
        if (p != 3'b000) begin
            chk("pulseOnehot", 512'($onehot(p)), 512'(1));
            if (p[0]) iCnt++;
            if (p[1]) dCnt++;
            if (p[2]) eCnt++;
            if (sb.size() == 0) begin
                totalCnt++;
                $display("FAIL unexpectedPulse: got pulses %b expected none", p);
            end else begin
                e = sb.pop_front();
                chk("pulseKind", 512'(p), 512'(3'b001 << e.kind));
                if (e.kind == 0) chk("mcInstrIn", mcInstrIn, e.line);
                if (e.kind == 1) chk("mcDataIn", mcDataIn, e.line);
                if (e.expCyc >= 0) chk("latency", 512'(cyc), 512'(e.expCyc));
            end
            if (p[0]) dropI = holdExtra ? 2 : 1;
            if (p[1]) dropD = holdExtra ? 2 : 1;
            if (p[2]) dropE = holdExtra ? 2 : 1;
        end
        if (ifc.hostReq && ifc.hostReqReady) begin
            if (sb.size() == 0) begin
                totalCnt++;
                $display("FAIL unexpectedAccept: got addr %0h expected no request", ifc.hostAddr);
            end else begin
                chk("hostAddr", 512'(ifc.hostAddr), 512'(sb[0].addr));
                chk("hostWrite", 512'(ifc.hostWrite), 512'(sb[0].kind == 2));
                if (sb[0].kind == 2) chk("hostWrData", ifc.hostWrData, sb[0].line);
            end
        end
        if (ifc.hostReq && prevReq) begin
            chk("holdAddr", 512'(ifc.hostAddr), 512'(prevAddr));
            chk("holdWrData", ifc.hostWrData, prevWrData);
        end
        if (ifc.hostReq && !prevReq) reqRises++;
        prevReq    = ifc.hostReq;
        prevAddr   = ifc.hostAddr;
        prevWrData = ifc.hostWrData;
        if (err2) begin
            err2Cnt++;
            err2Cyc = cyc;
        end
        if (ifc2.hostReq && !prevReq2) req2Cyc = cyc;
        prevReq2 = ifc2.hostReq;
        if (dataValid2 || instrValid2 || evictDone2) dv2Cnt++;
        @(posedge clk);
        #1;
        if (dropI == 1) instrMiss = 1'b0;
        if (dropD == 1) dataMiss  = 1'b0;
        if (dropE == 1) dataEvict = 1'b0;
        if (dropI > 0) dropI--;
        if (dropD > 0) dropD--;
        if (dropE > 0) dropE--;
    endtask

    task automatic pushExp(input int kind, input logic [31:0] addr, input logic [511:0] line,
                           input int expCyc);
        sbT e;
        e.kind = kind; e.addr = addr; e.line = line; e.expCyc = expCyc;
        sb.push_back(e);
    endtask

    task automatic waitDrain(input int limit);
        for (int k = 0; k < limit && sb.size() != 0; k++) tick();
        chk("drained", 512'(sb.size()), 512'(0));
    endtask

    task automatic runVec(input vecT v);
        readyDelay = v.readyDly;
        respDelay  = v.respDly;
        if (v.kind != 2) memLine[v.addr[7:4]] = v.line;
        pushExp(v.kind, v.expAddr, v.line, cyc + 3 + v.readyDly + v.respDly);
        case (v.kind)
            0:       begin instrMiss = 1'b1; instrAddr = v.addr; end
            1:       begin dataMiss  = 1'b1; dataAddr  = v.addr; end
            default: begin dataEvict = 1'b1; evictAddr = v.addr; evictData = v.line; end
        endcase
        waitDrain(40);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, d0, e0, r0;
        rst = 1'b1;
        instrMiss = 1'b0; dataMiss = 1'b0; dataEvict = 1'b0;
        instrAddr = '0; dataAddr = '0; evictAddr = '0; evictData = '0;
        dm2 = 1'b0;
        ifc2.hostReqReady = 1'b1;
        ifc2.hostRdValid  = 1'b0;
        ifc2.hostWrAck    = 1'b0;
        ifc2.hostRdData   = '0;
        for (int i = 0; i < 16; i++) memLine[i] = '0;

        vecs[0] = '{0, 32'h0000_1237, {64{8'hA5}},                 0,  0, 32'h0000_1230};
        vecs[1] = '{1, 32'h0000_2F45, {16{32'hDEAD_BEEF}},         0,  2, 32'h0000_2F40};
        vecs[2] = '{2, 32'h8000_00A9, {16{32'h1234_5678}},         1,  1, 32'h8000_00A0};
        vecs[3] = '{0, 32'hFFFF_FFFF, {8{64'h0123_4567_89AB_CDEF}}, 2,  0, 32'hFFFF_FFF0};
        vecs[4] = '{1, 32'h0000_0050, {512{1'b1}},                 0,  3, 32'h0000_0050};
        vecs[5] = '{1, 32'h0000_1068, {16{32'h0F0F_3C3C}},         10, 0, 32'h0000_1060};
        vecs[6] = '{2, 32'h0000_0000, {16{32'hCAFE_F00D}},         0,  0, 32'h0000_0000};

        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rstHostReq", 512'(ifc.hostReq), 512'(0));
        chk("rstHostWrite", 512'(ifc.hostWrite), 512'(0));
        chk("rstHostAddr", 512'(ifc.hostAddr), 512'(0));
        chk("rstHostWrData", ifc.hostWrData, 512'(0));
        chk("rstInstrIn", mcInstrIn, 512'(0));
        chk("rstDataIn", mcDataIn, 512'(0));
        chk("rstPulses", 512'({mcInstrValid, mcDataValid, evictDone, memTimeoutErr}), 512'(0));
        chk("rst2Outputs", instrIn2 | dataIn2, 512'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) runVec(vecs[i]);
        chk("mcDataHold", mcDataIn, vecs[5].line);
        chk("mcInstrHold", mcInstrIn, vecs[3].line);

        // simultaneous evict + data miss + instruction miss
        i0 = iCnt; d0 = dCnt; e0 = eCnt;
        readyDelay = 0; respDelay = 0;
        memLine[4'h9] = {16{32'h0BAD_F00D}};
        memLine[4'hC] = {16{32'h7777_1111}};
        pushExp(2, 32'h0000_0710, {8{64'h1111_2222_3333_4444}}, cyc + 3);
        pushExp(1, 32'h0000_0090, {16{32'h0BAD_F00D}}, -1);
        pushExp(0, 32'h0000_00C0, {16{32'h7777_1111}}, -1);
        dataEvict = 1'b1; evictAddr = 32'h0000_0715; evictData = {8{64'h1111_2222_3333_4444}};
        dataMiss  = 1'b1; dataAddr  = 32'h0000_0093;
        instrMiss = 1'b1; instrAddr = 32'h0000_00C1;
        waitDrain(60);
        repeat (2) tick();
        chk("orderEvictOnce", 512'(eCnt - e0), 512'(1));
        chk("orderDataOnce", 512'(dCnt - d0), 512'(1));
        chk("orderInstrOnce", 512'(iCnt - i0), 512'(1));

        // miss level held one cycle past its pulse must not reissue
        holdExtra = 1'b1;
        r0 = reqRises; d0 = dCnt;
        memLine[4'hE] = {16{32'h5555_AAAA}};
        pushExp(1, 32'h0000_00E0, {16{32'h5555_AAAA}}, cyc + 3);
        dataMiss = 1'b1; dataAddr = 32'h0000_00E2;
        waitDrain(40);
        repeat (4) tick();
        chk("noReissueReq", 512'(reqRises - r0), 512'(1));
        chk("noReissuePulse", 512'(dCnt - d0), 512'(1));
        holdExtra = 1'b0;

        // reset while waiting on a read; the late response must be dropped
        respDelay = 1;
        d0 = dCnt; r0 = reqRises;
        memLine[4'hD] = {16{32'h9999_0000}};
        pushExp(1, 32'h0000_00D0, {16{32'h9999_0000}}, -1);
        dataMiss = 1'b1; dataAddr = 32'h0000_00D4;
        tick();
        tick();
        rst = 1'b1; dataMiss = 1'b0;
        sb.delete();
        tick();
        rst = 1'b0;
        chk("abortHostReq", 512'(ifc.hostReq), 512'(0));
        chk("abortHostWrite", 512'(ifc.hostWrite), 512'(0));
        chk("abortHostAddr", 512'(ifc.hostAddr), 512'(0));
        chk("abortHostWrData", ifc.hostWrData, 512'(0));
        chk("abortDataIn", mcDataIn, 512'(0));
        chk("abortInstrIn", mcInstrIn, 512'(0));
        chk("abortPulses", 512'({mcInstrValid, mcDataValid, evictDone, memTimeoutErr}), 512'(0));
        repeat (4) tick();
        chk("abortNoData", 512'(dCnt - d0), 512'(0));
        chk("abortNoReq", 512'(reqRises - r0), 512'(1));
        respDelay = 0;

        // host never answers on the TIMEOUT=8 instance
        dm2 = 1'b1;
        tick();
        dm2 = 1'b0;
        for (int k = 0; k < 30 && err2Cnt == 0; k++) tick();
        chk("timeoutSeen", 512'(err2Cnt), 512'(1));
        chk("timeoutDelay", 512'(err2Cyc - req2Cyc), 512'(8));
        repeat (3) tick();
        chk("timeoutOnce", 512'(err2Cnt), 512'(1));
        chk("timeoutNoPulse", 512'(dv2Cnt), 512'(0));
        chk("timeoutIdle", 512'(ifc2.hostReq), 512'(0));
        chk("mainNoTimeout", 512'(memTimeoutErr), 512'(0));

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
